hc_sr04_scan_ctrl: RTL and testbench
====================================

# hc_sr04_scan_ctrl

Measurement sequencer for up to N HC-SR04 ultrasonic rangers that share one echo-timing datapath. It sits between the HC_SR04 AXI-Lite register slave and the sensor pins. It round-robins over the enabled sensors and, for each one, issues the trigger pulse, times the echo, enforces timeout and inter-ping gap, and emits one result record per ping to the register bank.

## Interface
Parameters:
- N_SENSORS, 4: number of sensors; 1..8.
- TRIG_CYCLES, 1000: trigger pulse width in ACLK cycles (10 µs @ 100 MHz).
- TIMEOUT_CYCLES, 3_800_000: maximum wait for echo rise, and maximum echo width.
- GAP_CYCLES, 6_000_000: quiet time after each ping before the next trigger.
- CNT_W, 23: counter/result width; must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, GAP_CYCLES).

Ports:
- ACLK, in, 1: clock. Single clock domain.
- ARESETN, in, 1: reset, synchronous, active-low.
- enable, in, 1: level; 0 stops scanning after the current ping completes.
- continuous, in, 1: 1 restarts the scan after the last enabled sensor; 0 performs a single pass.
- start, in, 1: one-cycle pulse; begins a pass when idle, ignored otherwise.
- sensor_mask, in, N_SENSORS: per-sensor enable.
- echo_i, in, N_SENSORS: raw asynchronous echo pins.
- trig_o, out, N_SENSORS: trigger pins; at most one bit high at any time.
- busy, out, 1: high in any state other than IDLE.
- result_valid, out, 1: one-cycle strobe.
- result_id, out, $clog2(N_SENSORS) (min 1): sensor index of the result.
- result_cycles, out, CNT_W: echo high time in cycles.
- result_timeout, out, 1: ping timed out, either no echo or echo too long.

## Operation
- States: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE: on start with enable=1 and sensor_mask≠0, select the lowest set mask bit and go to TRIG. Otherwise remain in IDLE.
- TRIG: drive trig_o[sel]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with the counter cleared.
- WAIT_RISE:
  - On a synchronized echo rise, go to MEASURE with the counter at 1.
  - If the counter reaches TIMEOUT_CYCLES, emit a result with result_timeout=1 and result_cycles=0, then go to GAP.
- MEASURE: count the cycles while the synchronized echo is high.
  - On the falling edge, emit the count with result_timeout=0.
  - If the count reaches TIMEOUT_CYCLES while echo is still high, emit result_cycles=TIMEOUT_CYCLES with result_timeout=1.
  - Either way, go to GAP.
- GAP: wait GAP_CYCLES, then pick the next set bit of sensor_mask strictly above sel.
  - If one is found and enable=1: go to TRIG.
  - If none is found, continuous=1 and enable=1: wrap to the lowest set bit and go to TRIG.
  - Otherwise: go to IDLE.
- sensor_mask is sampled only at selection points (IDLE exit and GAP exit). Changes mid-ping do not affect the current ping.
- If the mask becomes 0 at GAP exit, go to IDLE.
- Echo on non-selected sensors is ignored.
- An echo already high on entry to WAIT_RISE is not treated as a rise; only a 0→1 transition counts.

## Timing
- Reset: on a rising ACLK edge with ARESETN=0, go to IDLE with trig_o=0, busy=0, result_valid=0, result_id=0, result_cycles=0, result_timeout=0, and sel=0.
- Reset mid-ping drops trig_o on that same edge.
- start→trig_o high: 1 cycle. trig_o and busy are registered.
- Echo path: 2-flop synchronizer plus edge-detect register.
  - The rise is seen 3 cycles after the pin, and so is the fall, so result_cycles equals the pin high time ±1 cycle.
- result_valid: asserted the cycle after the fall or timeout is detected, for exactly 1 cycle.
  - result_* hold their value until the next strobe.
- Ping period per sensor = TRIG_CYCLES + (rise wait) + (echo width) + GAP_CYCLES + 1 cycle for the transition.
- A start pulse coincident with reset is ignored.

## Structure
- Package hc_sr04_pkg holds:
  - the state enum hc_sr04_state_t;
  - the result record struct (id, cycles, timeout);
  - the default cycle constants for 100 MHz.
- Sub-module hc_sr04_echo_sync: per-bit 2-flop synchronizer with rise/fall pulse outputs, instantiated once over the N_SENSORS bus.
- The top level holds the FSM, one shared CNT_W counter, and a next-set-bit priority function (wrap-around search).

## Test plan
Bench parameters: TRIG_CYCLES=10, TIMEOUT_CYCLES=200, GAP_CYCLES=50, N_SENSORS=4.
- mask=4'b0101, continuous=0, start; echo 40-cycle pulses → trig_o[0] high 10 cycles, result id=0, cycles=40±1, timeout=0. Then after a 50-cycle gap, trig_o[2], id=2. Then IDLE with busy=0.
- mask=4'b0010, no echo → result id=1, timeout=1, cycles=0 exactly 200 cycles after trig falls.
- Echo held high for 300 cycles → result cycles=200, timeout=1, then GAP.
- continuous=1, mask=4'b1001 → order 0,3,0,3. Drop enable during the second ping → that ping completes, then IDLE.
- ARESETN low for 1 cycle mid-TRIG → trig_o=0 and busy=0 on that edge; start during reset produces no trigger.
- mask=0 with start → stays IDLE, busy=0, no strobe. Mask changed mid-MEASURE → the current result is still reported for the original sensor.

Source files
------------

// File: rtl/hc_sr04_pkg.sv
// Shared types and 100 MHz default timing for the HC-SR04 scan sequencer.
// Sizes in the result record are the widest any instance can need.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } hc_sr04_state_t;

    localparam int MAX_ID_W  = 3;
    localparam int MAX_CNT_W = 32;

    typedef struct packed {
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_CNT_W-1:0] cycles;
        logic                 timeout;
    } hc_sr04_result_t;

    localparam int DEF_TRIG_CYCLES    = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 3_800_000;
    localparam int DEF_GAP_CYCLES     = 6_000_000;
    localparam int DEF_CNT_W          = 23;

endpackage

// File: rtl/hc_sr04_echo_sync.sv
// Two-flop synchronizer for the raw echo pins, plus a history register
// that turns the synchronized level into single-cycle rise/fall pulses.
module hc_sr04_echo_sync #(
    parameter int W = 4
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/hc_sr04_scan_ctrl.sv
// Round-robin HC-SR04 measurement sequencer: trigger, echo timing, timeout
// and inter-ping gap for the enabled sensors, sharing one cycle counter.
module hc_sr04_scan_ctrl
    import hc_sr04_pkg::*;
#(
    parameter int  N_SENSORS      = 4,
    parameter int  TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int  GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int  CNT_W          = DEF_CNT_W,
    localparam int ID_W           = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 continuous,
    input  logic                 start,
    input  logic [N_SENSORS-1:0] sensor_mask,
    input  logic [N_SENSORS-1:0] echo_i,
    output logic [N_SENSORS-1:0] trig_o,
    output logic                 busy,
    output logic                 result_valid,
    output logic [ID_W-1:0]      result_id,
    output logic [CNT_W-1:0]     result_cycles,
    output logic                 result_timeout,
    output hc_sr04_state_t       dbg_state
);

    // result_valid is a one-cycle strobe with no backpressure: the consumer
    // must capture result_* on the strobe; they then hold until the next one.

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    hc_sr04_state_t       state;
    hc_sr04_state_t       state_d;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_d;
    logic [ID_W-1:0]      sel;
    logic [ID_W-1:0]      sel_d;
    logic                 emit;
    logic                 emit_timeout;
    logic [CNT_W-1:0]     emit_cycles;
    logic [N_SENSORS-1:0] trig_d;
    logic                 busy_d;
    logic [N_SENSORS-1:0] echo_rise;
    logic [N_SENSORS-1:0] echo_fall;
    logic [ID_W:0]        first_hit;
    logic [ID_W:0]        next_hit;

    // First set mask bit at or after 'start', wrapping; MSB flags a hit.
    function automatic logic [ID_W:0] find_next(input logic [N_SENSORS-1:0] mask,
                                                input logic [ID_W:0]      from);
        logic [ID_W:0] hit;
        int            idx;
        hit = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            idx = (int'(from) + i) % N_SENSORS;
            if (mask[ID_W'(idx)]) begin
                hit = {1'b1, ID_W'(idx)};
            end
        end
        return hit;
    endfunction

    hc_sr04_echo_sync #(
        .W(N_SENSORS)
    ) u_echo_sync (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .din    (echo_i),
        .rise   (echo_rise),
        .fall   (echo_fall)
    );

    assign first_hit = find_next(sensor_mask, '0);
    assign next_hit  = find_next(sensor_mask, {1'b0, sel} + 1'b1);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state          <= IDLE;
            cnt            <= '0;
            sel            <= '0;
            trig_o         <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            sel          <= sel_d;
            trig_o       <= trig_d;
            busy         <= busy_d;
            result_valid <= emit;
            if (emit) begin
                result_id      <= sel;
                result_cycles  <= emit_cycles;
                result_timeout <= emit_timeout;
            end
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        sel_d        = sel;
        emit         = 1'b0;
        emit_cycles  = '0;
        emit_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && enable && first_hit[ID_W]) begin
                    state_d = TRIG;
                    sel_d   = first_hit[ID_W-1:0];
                    cnt_d   = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_RISE: begin
                // Only a fresh edge counts; an echo already high is ignored.
                if (echo_rise[sel]) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    emit         = 1'b1;
                    emit_timeout = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall[sel]) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    emit        = 1'b1;
                    emit_cycles = cnt;
                end else if (cnt == TIMEOUT_MAX) begin
                    state_d      = GAP;
                    cnt_d        = '0;
                    emit         = 1'b1;
                    emit_cycles  = cnt;
                    emit_timeout = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    // A hit at or below sel means the search wrapped.
                    if (enable && next_hit[ID_W] &&
                        ((next_hit[ID_W-1:0] > sel) || continuous)) begin
                        state_d = TRIG;
                        sel_d   = next_hit[ID_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trig_d = '0;
        if (state_d == TRIG) begin
            trig_d = N_SENSORS'(1) << sel_d;
        end
        busy_d = (state_d != IDLE);
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_hc_sr04_scan_ctrl.sv
// Directed bench for hc_sr04_scan_ctrl with short trigger/timeout/gap
// settings; expected records are hand-computed from the sensor protocol.
module tb_hc_sr04_scan_ctrl;
    import hc_sr04_pkg::*;

    localparam int N   = 4;
    localparam int CW  = 23;
    localparam int IDW = 2;

    logic           clk;
    logic           arst_n;
    logic           enable;
    logic           continuous;
    logic           start;
    logic [N-1:0]   sensor_mask;
    logic [N-1:0]   echo_i;
    logic [N-1:0]   trig_o;
    logic           busy;
    logic           result_valid;
    logic [IDW-1:0] result_id;
    logic [CW-1:0]  result_cycles;
    logic           result_timeout;
    hc_sr04_state_t dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    hc_sr04_scan_ctrl #(
        .N_SENSORS     (N),
        .TRIG_CYCLES   (10),
        .TIMEOUT_CYCLES(200),
        .GAP_CYCLES    (50),
        .CNT_W         (CW)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (arst_n),
        .enable        (enable),
        .continuous    (continuous),
        .start         (start),
        .sensor_mask   (sensor_mask),
        .echo_i        (echo_i),
        .trig_o        (trig_o),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_id     (result_id),
        .result_cycles (result_cycles),
        .result_timeout(result_timeout),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic hc_sr04_result_t mk_res(input int id, input int cyc, input bit to);
        hc_sr04_result_t r;
        r.id      = 3'(id);
        r.cycles  = 32'(cyc);
        r.timeout = to;
        return r;
    endfunction

    // Waits for trig_o[s] to rise, checks it is the only trigger, and
    // returns once it has fallen; n = cycles waited before the rise.
    task automatic wait_trig(input int s, output int n);
        int w;
        n = 0;
        while (trig_o[2'(s)] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("trig_seen", 32'(trig_o[2'(s)]), 1);
        check("trig_onehot", 32'(trig_o), 32'(1) << s);
        w = 0;
        while (trig_o[2'(s)] === 1'b1 && w < 100) begin
            w++;
            tick();
        end
        check("trig_width", w, 10);
    endtask

    task automatic drive_echo(input int s, input int dly, input int width);
        repeat (dly) tick();
        echo_i[2'(s)] = 1'b1;
        repeat (width) tick();
        echo_i[2'(s)] = 1'b0;
    endtask

    task automatic wait_result(input int limit, output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("valid_seen", 32'(result_valid), 1);
    endtask

    task automatic check_result(input hc_sr04_result_t exp, input int tol);
        check("res_id", 32'(result_id), 32'(exp.id));
        n_cmp++;
        assert ((32'(result_cycles) + 32'(tol) >= exp.cycles) &&
                (32'(result_cycles) <= exp.cycles + 32'(tol))) else begin
            n_mis++;
            $error("FAIL res_cycles: observed %0d expected %0d +/- %0d",
                   result_cycles, exp.cycles, tol);
        end
        check("res_timeout", 32'(result_timeout), 32'(exp.timeout));
        tick();
        check("strobe_one_cycle", 32'(result_valid), 0);
        check("res_id_held", 32'(result_id), 32'(exp.id));
    endtask

    initial begin
        int n;
        int seen;
        arst_n      = 1'b0;
        enable      = 1'b1;
        continuous  = 1'b0;
        start       = 1'b0;
        sensor_mask = '0;
        echo_i      = '0;
        repeat (3) tick();
        check("rst_trig", 32'(trig_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_id", 32'(result_id), 0);
        check("rst_cycles", 32'(result_cycles), 0);
        check("rst_timeout", 32'(result_timeout), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        arst_n = 1'b1;
        tick();

        // Single pass over sensors 0 and 2 with 40-cycle echoes.
        sensor_mask = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_trig0", 32'(trig_o), 32'b0001);
        check("start_busy", 32'(busy), 1);
        wait_trig(0, n);
        drive_echo(0, 4, 40);
        wait_result(20, n);
        check_result(mk_res(0, 40, 1'b0), 1);
        wait_trig(2, n);
        check("gap_len", n + 1, 50);
        drive_echo(2, 7, 40);
        wait_result(20, n);
        check_result(mk_res(2, 40, 1'b0), 1);
        repeat (50) tick();
        check("pass_end_busy", 32'(busy), 0);
        check("pass_end_state", 32'(dbg_state), 32'(IDLE));

        // No echo on sensor 1; echo on unselected sensor 3 is ignored.
        sensor_mask = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig(1, n);
        echo_i[3] = 1'b1;
        wait_result(400, n);
        echo_i[3] = 1'b0;
        check("rise_timeout_latency", n, 200);
        check_result(mk_res(1, 0, 1'b1), 0);
        repeat (52) tick();
        check("t2_idle_busy", 32'(busy), 0);

        // Echo stuck high for 300 cycles: clipped at the timeout.
        sensor_mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig(0, n);
        repeat (5) tick();
        echo_i[0] = 1'b1;
        wait_result(400, n);
        check_result(mk_res(0, 200, 1'b1), 0);
        check("long_echo_gap", 32'(dbg_state), 32'(GAP));
        repeat (96) tick();
        echo_i[0] = 1'b0;
        check("long_echo_idle", 32'(busy), 0);

        // Continuous scan over 0,3,0,3; enable dropped in the last ping.
        continuous  = 1'b1;
        sensor_mask = 4'b1001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig(0, n);
        drive_echo(0, 3, 20);
        wait_result(20, n);
        check_result(mk_res(0, 20, 1'b0), 1);
        wait_trig(3, n);
        drive_echo(3, 3, 25);
        wait_result(20, n);
        check_result(mk_res(3, 25, 1'b0), 1);
        wait_trig(0, n);
        check("wrap_gap_len", n + 1, 50);
        drive_echo(0, 3, 30);
        wait_result(20, n);
        check_result(mk_res(0, 30, 1'b0), 1);
        wait_trig(3, n);
        enable = 1'b0;
        drive_echo(3, 3, 35);
        wait_result(20, n);
        check_result(mk_res(3, 35, 1'b0), 1);
        repeat (52) tick();
        check("en_drop_busy", 32'(busy), 0);
        check("en_drop_trig", 32'(trig_o), 0);
        enable     = 1'b1;
        continuous = 1'b0;

        // Reset pulse in the middle of a trigger, with start asserted.
        sensor_mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_trig", 32'(trig_o), 32'b0001);
        arst_n = 1'b0;
        start  = 1'b1;
        tick();
        check("mid_rst_trig", 32'(trig_o), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_id", 32'(result_id), 0);
        check("mid_rst_cycles", 32'(result_cycles), 0);
        arst_n = 1'b1;
        start  = 1'b0;
        repeat (5) tick();
        check("post_rst_trig", 32'(trig_o), 0);
        check("post_rst_busy", 32'(busy), 0);

        // Empty mask: start is refused.
        sensor_mask = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1 || result_valid === 1'b1 || trig_o !== '0) seen++;
            tick();
        end
        check("mask0_activity", seen, 0);
        check("mask0_state", 32'(dbg_state), 32'(IDLE));

        // Mask rewritten mid-measurement: result still belongs to sensor 2.
        sensor_mask = 4'b0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig(2, n);
        repeat (2) tick();
        echo_i[2] = 1'b1;
        repeat (10) tick();
        sensor_mask = 4'b0001;
        repeat (20) tick();
        echo_i[2] = 1'b0;
        wait_result(20, n);
        check_result(mk_res(2, 30, 1'b0), 1);
        repeat (52) tick();
        check("mask_chg_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
